mmio_hub: RTL and testbench
===========================

Name: mmio_hub

Overview:
- Parametrised successor to the fixed-map MMIO block.
- Decodes CPU load/store traffic into a DMEM window and a grid of NUM_SLOTS coprocessor slots of REGS_PER_SLOT registers each.
- Each slot's registers are double-buffered. CPU writes land in a shadow bank and reach the coprocessors either immediately (direct mode) or on the next frame_tick after a commit request (shadowed mode), so physics/VGA/collision inputs change atomically per frame.
- Sits between the processor data port and the dmem and coprocessor instances.

Parameters:
- DATA_W, 32, bus and register width
- ADDR_W, 13, CPU address width; MSB selects MMIO (1) or DMEM (0)
- SLOT_BITS, 5, slot field width; defaults give address[11:7]
- REG_BITS, 5, register field width; defaults give address[6:2]
- NUM_SLOTS, 16, implemented slots; must be < 2^SLOT_BITS - 1
- REGS_PER_SLOT, 8, implemented registers per slot; must be < 2^REG_BITS - 1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- address  in  ADDR_W  CPU byte address; bits [1:0] ignored
- data_in  in  DATA_W  CPU write data
- wren  in  1  CPU write enable
- data_out  out  DATA_W  read data, one-cycle latency
- dmem_address  out  ADDR_W-1  = address[ADDR_W-2:0], combinational
- dmem_wren  out  1  = wren & ~address[ADDR_W-1], combinational
- dmem_q  in  DATA_W  DMEM read data
- frame_tick  in  1  one-cycle frame strobe (vsync)
- slot_status_in  in  NUM_SLOTS*DATA_W  per-slot coprocessor result; slot s at [s*DATA_W +: DATA_W]
- reg_out  out  NUM_SLOTS*REGS_PER_SLOT*DATA_W  active registers; (s,r) at [(s*REGS_PER_SLOT+r)*DATA_W +: DATA_W]
- commit_pulse  out  1  high one cycle when a shadowed commit occurs

Behaviour:
Decode
- mmio = address[ADDR_W-1]; slot = the SLOT_BITS field; reg = the REG_BITS field.
- Control slot CS = all-ones slot index.
- Writes to slot >= NUM_SLOTS (other than CS) or reg >= REGS_PER_SLOT are ignored.

Control slot registers
- reg0 CTRL (write-only): writing bit0=1 sets commit_pending. Reads as 0.
- reg1 MODE (R/W): bit s = 1 means slot s is direct, 0 means shadowed; upper bits read 0.
- reg2 STATUS (RO): bit0 = commit_pending, others 0.
- reg3 FRAME_COUNT (RO): increments on every frame_tick; wraps 0xFFFFFFFF to 0.

Slot writes (wren & mmio & valid slot/reg)
- Shadow(s,r) <= data_in at the clock edge.
- If MODE[s]=1, active(s,r) <= data_in at the same edge.

Commit
- Occurs on a cycle with frame_tick=1 and commit_pending=1.
- Every shadowed slot copies all shadow to active in that edge; direct slots are unaffected.
- commit_pending clears; commit_pulse=1 in the following cycle.
- A slot write in the commit cycle is forwarded: active receives data_in.
- A CTRL commit write in the same cycle as frame_tick sets pending for the next frame_tick only; it does not commit now.
- A CTRL write while already pending leaves pending=1 (no counting).
- MODE written 0→1 while pending: that slot's stale shadow does not copy to active at commit, since it is now direct.

Reads (registered, latency 1)
- Edge N samples address; data_out is valid during cycle N+1.
- mmio=0: data_out = dmem_q (dmem_q is sampled combinationally through a registered select flag).
- Valid slot, reg < REGS_PER_SLOT: shadow(s,r).
- Valid slot, reg = all-ones: slot_status_in for slot s.
- Control slot: as defined above.
- Anything else: 0.
- A read and write to the same register in one cycle returns the old value.

Reset
- Shadow, active, FRAME_COUNT, commit_pending, commit_pulse, and the data_out register all clear to 0.
- MODE resets to all ones (all slots direct).
- Reset mid-pending discards the commit.
- dmem_wren follows its inputs during reset; MMIO writes are ignored while reset=1.

Test Plan:
- Reset, then read slot0 reg0 (address 0x1000) → data_out=0 at cycle+1. MODE read (0x1F84) → 0x0000FFFF.
- Direct write 0x016000FA to 0x1000 → reg_out(0,0)=0x016000FA the next cycle. Readback at 0x1000 returns it one cycle after the read address.
- Write MODE=0, write 0x00010000 to slot1 reg1 (0x1084) → reg_out(1,1) stays 0. Write CTRL=1; STATUS=1. Pulse frame_tick → reg_out(1,1)=0x00010000, commit_pulse high one cycle, STATUS=0.
- Shadowed mode: CTRL=1 write coincident with frame_tick → no commit. Next frame_tick commits. A slot write coincident with the commit edge lands in active.
- Writes to slot 20, to reg 10, and to address 0x0004 → reg_out unchanged; only the last raises dmem_wren. Reading slot 3 reg 0x1F returns slot_status_in[3].
- 3 frame_ticks then reset asserted mid-pending → FRAME_COUNT 3, then 0. Pending cleared; no commit on the following frame_tick.

Source files
------------

// File: rtl/mmio_hub.sv
// CPU-facing MMIO hub: splits load/store traffic between DMEM and a grid of
// double-buffered coprocessor register slots with frame-atomic commit.
module mmio_hub #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 13,
    parameter int SLOT_BITS     = 5,
    parameter int REG_BITS      = 5,
    parameter int NUM_SLOTS     = 16,
    parameter int REGS_PER_SLOT = 8
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [ADDR_W-1:0]                         address,
    input  logic [DATA_W-1:0]                         data_in,
    input  logic                                      wren,
    output logic [DATA_W-1:0]                         data_out,
    output logic [ADDR_W-2:0]                         dmem_address,
    output logic                                      dmem_wren,
    input  logic [DATA_W-1:0]                         dmem_q,
    input  logic                                      frame_tick,
    input  logic [NUM_SLOTS*DATA_W-1:0]               slot_status_in,
    output logic [NUM_SLOTS*REGS_PER_SLOT*DATA_W-1:0] reg_out,
    output logic                                      commit_pulse
);

    localparam int SLOT_LSB = REG_BITS + 2;
    localparam logic [SLOT_BITS-1:0] CS_SLOT      = '1;
    localparam logic [REG_BITS-1:0]  STATUS_REG   = '1;
    localparam logic [SLOT_BITS-1:0] NUM_SLOTS_V  = SLOT_BITS'(NUM_SLOTS);
    localparam logic [REG_BITS-1:0]  NUM_REGS_V   = REG_BITS'(REGS_PER_SLOT);
    localparam logic [REG_BITS-1:0]  R_CTRL       = REG_BITS'(0);
    localparam logic [REG_BITS-1:0]  R_MODE       = REG_BITS'(1);
    localparam logic [REG_BITS-1:0]  R_STATUS     = REG_BITS'(2);
    localparam logic [REG_BITS-1:0]  R_FRAME      = REG_BITS'(3);

    logic [DATA_W-1:0] shadow [NUM_SLOTS][REGS_PER_SLOT];
    logic [DATA_W-1:0] active [NUM_SLOTS][REGS_PER_SLOT];

    logic [NUM_SLOTS-1:0] mode;
    logic                 commit_pending;
    logic [DATA_W-1:0]    frame_count;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_dmem;
    logic [DATA_W-1:0]    rd_next;

    logic                 mmio;
    logic [SLOT_BITS-1:0] slot_idx;
    logic [REG_BITS-1:0]  reg_idx;
    logic                 is_ctrl;
    logic                 slot_wr;
    logic                 ctrl_wr;
    logic                 commit;
    logic                 pend_set;
    logic                 unused_addr_bits;

    assign mmio     = address[ADDR_W-1];
    assign slot_idx = address[SLOT_LSB +: SLOT_BITS];
    assign reg_idx  = address[2 +: REG_BITS];
    assign is_ctrl  = (slot_idx == CS_SLOT);
    assign unused_addr_bits = ^address[1:0];

    assign slot_wr  = wren && mmio && (slot_idx < NUM_SLOTS_V) && (reg_idx < NUM_REGS_V);
    assign ctrl_wr  = wren && mmio && is_ctrl;
    assign commit   = frame_tick && commit_pending;
    assign pend_set = ctrl_wr && (reg_idx == R_CTRL) && data_in[0];

    assign dmem_address = address[ADDR_W-2:0];
    assign dmem_wren    = wren & ~mmio;

    // DMEM data arrives a cycle after its address, so only the select is registered.
    assign data_out = rd_dmem ? dmem_q : rd_data;

    for (genvar gs = 0; gs < NUM_SLOTS; gs++) begin : g_slot
        for (genvar gr = 0; gr < REGS_PER_SLOT; gr++) begin : g_reg
            assign reg_out[(gs*REGS_PER_SLOT+gr)*DATA_W +: DATA_W] = active[gs][gr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode           <= '1;
            commit_pending <= 1'b0;
            frame_count    <= '0;
            commit_pulse   <= 1'b0;
        end else begin
            commit_pulse <= commit;
            // A request arriving with the tick itself waits for the following tick.
            commit_pending <= pend_set || (commit_pending && !frame_tick);
            if (frame_tick) frame_count <= frame_count + 1'b1;
            if (ctrl_wr && reg_idx == R_MODE) mode <= data_in[NUM_SLOTS-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int r = 0; r < REGS_PER_SLOT; r++) begin
                    shadow[s][r] <= '0;
                    active[s][r] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int r = 0; r < REGS_PER_SLOT; r++) begin
                    if (commit && !mode[s]) active[s][r] <= shadow[s][r];
                    // Later assignment wins, so a write in the commit cycle is forwarded.
                    if (slot_wr && slot_idx == SLOT_BITS'(s) && reg_idx == REG_BITS'(r)) begin
                        shadow[s][r] <= data_in;
                        if (mode[s] || commit) active[s][r] <= data_in;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        if (mmio) begin
            if (is_ctrl) begin
                case (reg_idx)
                    R_MODE:   rd_next[NUM_SLOTS-1:0] = mode;
                    R_STATUS: rd_next[0] = commit_pending;
                    R_FRAME:  rd_next = frame_count;
                    default:  rd_next = '0;
                endcase
            end else begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (slot_idx == SLOT_BITS'(s)) begin
                        for (int r = 0; r < REGS_PER_SLOT; r++) begin
                            if (reg_idx == REG_BITS'(r)) rd_next = shadow[s][r];
                        end
                        if (reg_idx == STATUS_REG) rd_next = slot_status_in[s*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
            rd_dmem <= 1'b0;
        end else begin
            rd_data <= rd_next;
            rd_dmem <= ~mmio;
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: spec-level model compared every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_mmio_hub;

    localparam int DW = 32;
    localparam int NS = 16;
    localparam int NR = 8;

    logic              clock;
    logic              reset;
    logic [12:0]       address;
    logic [DW-1:0]     data_in;
    logic              wren;
    logic [DW-1:0]     data_out;
    logic [11:0]       dmem_address;
    logic              dmem_wren;
    logic [DW-1:0]     dmem_q;
    logic              frame_tick;
    logic [NS*DW-1:0]  slot_status_in;
    logic [NS*NR*DW-1:0] reg_out;
    logic              commit_pulse;

    int tests = 0;
    int fails = 0;

    mmio_hub dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .data_in        (data_in),
        .wren           (wren),
        .data_out       (data_out),
        .dmem_address   (dmem_address),
        .dmem_wren      (dmem_wren),
        .dmem_q         (dmem_q),
        .frame_tick     (frame_tick),
        .slot_status_in (slot_status_in),
        .reg_out        (reg_out),
        .commit_pulse   (commit_pulse)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- model state ----------------
    logic [31:0] m_shadow [NS][NR];
    logic [31:0] m_active [NS][NR];
    logic [15:0] m_mode;
    bit          m_pending;
    logic [31:0] m_fc;
    bit          m_pulse;
    logic [31:0] m_rd;
    bit          m_rd_dmem;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] model_read(input logic [12:0] a);
        int s;
        int r;
        s = int'(a[11:7]);
        r = int'(a[6:2]);
        if (!a[12]) return 32'h0;
        if (s == 31) begin
            if (r == 1) return {16'h0, m_mode};
            if (r == 2) return {31'h0, m_pending};
            if (r == 3) return m_fc;
            return 32'h0;
        end
        if (s < NS) begin
            if (r < NR) return m_shadow[s][r];
            if (r == 31) return slot_status_in[s*32 +: 32];
        end
        return 32'h0;
    endfunction

    always @(posedge clock) begin : model
        int ws;
        int wr_i;
        bit do_commit;
        bit set_pend;
        logic [15:0] old_mode;
        if (reset) begin
            for (int s = 0; s < NS; s++)
                for (int r = 0; r < NR; r++) begin
                    m_shadow[s][r] = 32'h0;
                    m_active[s][r] = 32'h0;
                end
            m_mode    = 16'hFFFF;
            m_pending = 1'b0;
            m_fc      = 32'h0;
            m_pulse   = 1'b0;
            m_rd      = 32'h0;
            m_rd_dmem = 1'b0;
            m_valid   = 1'b1;
        end else begin
            m_rd      = model_read(address);
            m_rd_dmem = !address[12];
            do_commit = frame_tick && m_pending;
            old_mode  = m_mode;
            set_pend  = 1'b0;
            m_pulse   = do_commit;
            if (do_commit)
                for (int s = 0; s < NS; s++)
                    if (!old_mode[s])
                        for (int r = 0; r < NR; r++) m_active[s][r] = m_shadow[s][r];
            if (wren && address[12]) begin
                ws   = int'(address[11:7]);
                wr_i = int'(address[6:2]);
                if (ws < NS && wr_i < NR) begin
                    m_shadow[ws][wr_i] = data_in;
                    if (old_mode[ws] || do_commit) m_active[ws][wr_i] = data_in;
                end else if (ws == 31) begin
                    if (wr_i == 0 && data_in[0]) set_pend = 1'b1;
                    if (wr_i == 1) m_mode = data_in[15:0];
                end
            end
            m_pending = set_pend || (m_pending && !frame_tick);
            if (frame_tick) m_fc = m_fc + 32'd1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ro(input int s, input int r);
        return reg_out[(s*NR+r)*32 +: 32];
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            check("data_out", data_out, m_rd_dmem ? dmem_q : m_rd);
            check("commit_pulse", {31'h0, commit_pulse}, {31'h0, m_pulse});
            check("dmem_wren", {31'h0, dmem_wren}, {31'h0, wren & ~address[12]});
            check("dmem_address", {20'h0, dmem_address}, {20'h0, address[11:0]});
            begin : reg_cmp
                bit bad;
                bad = 1'b0;
                tests++;
                for (int s = 0; s < NS; s++)
                    for (int r = 0; r < NR; r++)
                        if (!bad && ro(s, r) !== m_active[s][r]) begin
                            bad = 1'b1;
                            fails++;
                            $display("FAIL reg_out(%0d,%0d): got %h expected %h at %0t",
                                     s, r, ro(s, r), m_active[s][r], $time);
                        end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        wren    = 1'b1;
        tick();
        wren    = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [31:0] q);
        address = a;
        wren    = 1'b0;
        tick();
        q = data_out;
    endtask

    task automatic ft();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] q;
        reset      = 1'b1;
        address    = 13'h0;
        data_in    = 32'h0;
        wren       = 1'b0;
        dmem_q     = 32'hDEADBEEF;
        frame_tick = 1'b0;
        for (int s = 0; s < NS; s++) slot_status_in[s*32 +: 32] = 32'hABCD0000 | s;
        tick();
        tick();
        check("rst reg_out00", ro(0, 0), 32'h0);
        check("rst commit_pulse", {31'h0, commit_pulse}, 32'h0);
        check("rst data_out", data_out, 32'h0);
        reset = 1'b0;

        rd(13'h1000, q); check("rd slot0 reg0 after reset", q, 32'h0);
        rd(13'h1F84, q); check("rd MODE after reset", q, 32'h0000FFFF);

        wr(13'h1000, 32'h016000FA);
        check("direct write active", ro(0, 0), 32'h016000FA);
        rd(13'h1000, q); check("direct readback", q, 32'h016000FA);

        wr(13'h1F84, 32'h0);
        wr(13'h1084, 32'h00010000);
        check("shadowed write held", ro(1, 1), 32'h0);
        rd(13'h1084, q); check("shadow readback", q, 32'h00010000);
        wr(13'h1F80, 32'h1);
        rd(13'h1F88, q); check("STATUS pending", q, 32'h1);
        address = 13'h0;
        ft();
        check("commit active", ro(1, 1), 32'h00010000);
        check("commit_pulse high", {31'h0, commit_pulse}, 32'h1);
        tick();
        check("commit_pulse one cycle", {31'h0, commit_pulse}, 32'h0);
        rd(13'h1F88, q); check("STATUS cleared", q, 32'h0);

        wr(13'h1084, 32'h22222222);
        check("shadowed write 2 held", ro(1, 1), 32'h00010000);
        address = 13'h1F80; data_in = 32'h1; wren = 1'b1; frame_tick = 1'b1;
        tick();
        wren = 1'b0; frame_tick = 1'b0;
        check("ctrl+tick no commit pulse", {31'h0, commit_pulse}, 32'h0);
        check("ctrl+tick no commit", ro(1, 1), 32'h00010000);
        rd(13'h1F88, q); check("STATUS pending after ctrl+tick", q, 32'h1);
        address = 13'h1088; data_in = 32'h33333333; wren = 1'b1; frame_tick = 1'b1;
        tick();
        wren = 1'b0; frame_tick = 1'b0;
        check("second commit", ro(1, 1), 32'h22222222);
        check("forwarded write in commit", ro(1, 2), 32'h33333333);
        check("second commit pulse", {31'h0, commit_pulse}, 32'h1);

        address = 13'h1A00; data_in = 32'hBAD0BAD0; wren = 1'b1;
        #1 check("slot20 dmem_wren", {31'h0, dmem_wren}, 32'h0);
        tick();
        address = 13'h1028; wren = 1'b1;
        #1 check("reg10 dmem_wren", {31'h0, dmem_wren}, 32'h0);
        tick();
        address = 13'h0004; wren = 1'b1;
        #1 check("dmem write wren", {31'h0, dmem_wren}, 32'h1);
        check("dmem write addr", {20'h0, dmem_address}, 32'h4);
        tick();
        wren = 1'b0;
        check("invalid writes slot0", ro(0, 0), 32'h016000FA);
        check("no alias slot20->4", ro(4, 0), 32'h0);
        check("no alias reg10->2", ro(0, 2), 32'h0);
        rd(13'h11FC, q); check("slot3 status", q, 32'hABCD0003);
        rd(13'h0004, q); check("dmem read", q, 32'hDEADBEEF);
        rd(13'h1A00, q); check("rd slot20", q, 32'h0);
        rd(13'h1028, q); check("rd reg10", q, 32'h0);

        wr(13'h1000, 32'h55555555);
        check("read-during-write old", data_out, 32'h016000FA);
        rd(13'h1000, q); check("read after write", q, 32'h55555555);

        wr(13'h1100, 32'h44444444);
        wr(13'h1F80, 32'h1);
        wr(13'h1F84, 32'h4);
        address = 13'h0;
        ft();
        check("mode 0->1 no stale copy", ro(2, 0), 32'h0);
        check("shadowed slot0 commits", ro(0, 0), 32'h55555555);
        check("mode change commit pulse", {31'h0, commit_pulse}, 32'h1);
        wr(13'h1100, 32'h66666666);
        check("slot2 now direct", ro(2, 0), 32'h66666666);

        reset = 1'b1; tick(); reset = 1'b0;
        address = 13'h0;
        ft(); ft(); ft();
        rd(13'h1F8C, q); check("FRAME_COUNT 3", q, 32'h3);
        wr(13'h1F84, 32'h0);
        wr(13'h1000, 32'h77777777);
        wr(13'h1F80, 32'h1);
        rd(13'h1F88, q); check("pending before reset", q, 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        rd(13'h1F8C, q); check("FRAME_COUNT reset", q, 32'h0);
        rd(13'h1F88, q); check("pending reset", q, 32'h0);
        wr(13'h1F84, 32'h0);
        wr(13'h1000, 32'h99999999);
        address = 13'h0;
        ft();
        check("no commit after reset pulse", {31'h0, commit_pulse}, 32'h0);
        check("no commit after reset active", ro(0, 0), 32'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
